adc_capture_ctrl: RTL and testbench

//  Trigger-based capture sequencer placed directly upstream of the ADC sample buffer.

---
 rtl/adc_capture_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_ctrl.sv
// rtl/adc_capture_ctrl.sv - trigger-based ADC capture sequencer feeding the sample buffer write port
// Optional build macro CAPTURE_DECIM_EN adds the decim input (accept every (decim+1)-th valid sample).
module adc_capture_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 12,
  parameter int PRE_SAMPLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  adc_valid,
  input  logic [DATA_WIDTH-1:0] adc_data,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] trig_level,
  input  logic                  trig_rising,
  input  logic [ADDR_WIDTH-1:0] post_count,
`ifdef CAPTURE_DECIM_EN
  input  logic [7:0]            decim,
`endif
  output logic                  write_en,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  triggered,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic [ADDR_WIDTH-1:0] start_addr
);

  localparam int PW = $clog2(PRE_SAMPLES + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [PW-1:0]         prefill_q, prefill_d;
  logic                  hist_valid_q, hist_valid_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic [DATA_WIDTH-1:0] level_q, level_d;
  logic                  rising_q, rising_d;
  logic [ADDR_WIDTH-1:0] post_q, post_d;
  logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;
  logic                  write_en_q, write_en_d;
  logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  triggered_q, triggered_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_WIDTH-1:0] start_addr_q, start_addr_d;
  logic                  busy_w, accept, crossing, gate_ok;
`ifdef CAPTURE_DECIM_EN
  logic [7:0]            decim_q, decim_d;
  logic [7:0]            phase_q, phase_d;
`endif

  assign busy_w   = (state_q == S_ARMED) || (state_q == S_POST);
  assign gate_ok  = (prefill_q == PW'(PRE_SAMPLES));
  assign crossing = hist_valid_q &&
                    (rising_q ? ((prev_q < level_q) && (adc_data >= level_q))
                              : ((prev_q > level_q) && (adc_data <= level_q)));
`ifdef CAPTURE_DECIM_EN
  assign accept   = adc_valid && busy_w && (phase_q == 8'd0);
`else
  assign accept   = adc_valid && busy_w;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    prefill_d    = prefill_q;
    hist_valid_d = hist_valid_q;
    prev_d       = prev_q;
    level_d      = level_q;
    rising_d     = rising_q;
    post_d       = post_q;
    remaining_d  = remaining_q;
    write_en_d   = 1'b0;
    write_addr_d = write_addr_q;
    wr_data_d    = wr_data_q;
    triggered_d  = triggered_q;
    done_d       = done_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;
`ifdef CAPTURE_DECIM_EN
    decim_d      = decim_q;
    phase_d      = phase_q;
`endif
    if (abort) begin
      state_d     = S_IDLE;
      triggered_d = 1'b0;
      done_d      = 1'b0;
    end else if (arm && !busy_w) begin
      state_d      = S_ARMED;
      level_d      = trig_level;
      rising_d     = trig_rising;
      post_d       = post_count;
      ptr_d        = '0;
      prefill_d    = '0;
      hist_valid_d = 1'b0;
      triggered_d  = 1'b0;
      done_d       = 1'b0;
      trig_addr_d  = '0;
`ifdef CAPTURE_DECIM_EN
      decim_d      = decim;
      phase_d      = 8'd0;
`endif
    end else begin
`ifdef CAPTURE_DECIM_EN
      // Phase advances on every valid sample seen while capturing, accepted or not.
      if (adc_valid && busy_w)
        phase_d = (phase_q == decim_q) ? 8'd0 : phase_q + 8'd1;
`endif
      if (accept) begin
        write_en_d   = 1'b1;
        write_addr_d = ptr_q;
        wr_data_d    = adc_data;
        ptr_d        = ptr_q + ADDR_WIDTH'(1);
        prev_d       = adc_data;
        hist_valid_d = 1'b1;
        if (!gate_ok)
          prefill_d = prefill_q + PW'(1);
        if (state_q == S_ARMED) begin
          if (crossing && gate_ok) begin
            trig_addr_d = ptr_q;
            triggered_d = 1'b1;
            remaining_d = post_q;
            if (post_q == '0) begin
              state_d      = S_DONE;
              done_d       = 1'b1;
              start_addr_d = ptr_q + ADDR_WIDTH'(1);
            end else begin
              state_d = S_POST;
            end
          end
        end else begin
          remaining_d = remaining_q - ADDR_WIDTH'(1);
          if (remaining_q == ADDR_WIDTH'(1)) begin
            state_d      = S_DONE;
            done_d       = 1'b1;
            start_addr_d = ptr_q + ADDR_WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      prefill_q    <= '0;
      hist_valid_q <= 1'b0;
      prev_q       <= '0;
      level_q      <= '0;
      rising_q     <= 1'b0;
      post_q       <= '0;
      remaining_q  <= '0;
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      wr_data_q    <= '0;
      triggered_q  <= 1'b0;
      done_q       <= 1'b0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
`ifdef CAPTURE_DECIM_EN
      decim_q      <= 8'd0;
      phase_q      <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      prefill_q    <= prefill_d;
      hist_valid_q <= hist_valid_d;
      prev_q       <= prev_d;
      level_q      <= level_d;
      rising_q     <= rising_d;
      post_q       <= post_d;
      remaining_q  <= remaining_d;
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      wr_data_q    <= wr_data_d;
      triggered_q  <= triggered_d;
      done_q       <= done_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
`ifdef CAPTURE_DECIM_EN
      decim_q      <= decim_d;
      phase_q      <= phase_d;
`endif
    end
  end

  assign write_en   = write_en_q;
  assign write_addr = write_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_w;
  assign triggered  = triggered_q;
  assign done       = done_q;
  assign trig_addr  = trig_addr_q;
  assign start_addr = start_addr_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb/tb_adc_capture_ctrl.sv - randomized scoreboard bench for adc_capture_ctrl
module tb_adc_capture_ctrl;

  localparam int PRE = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        adc_valid = 1'b0;
  logic [7:0]  adc_data = '0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  trig_level = '0;
  logic        trig_rising = 1'b0;
  logic [11:0] post_count = '0;
`ifdef CAPTURE_DECIM_EN
  logic [7:0]  decim = '0;
`endif
  logic        write_en;
  logic [11:0] write_addr;
  logic [7:0]  wr_data;
  logic        busy, triggered, done;
  logic [11:0] trig_addr, start_addr;

  adc_capture_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .PRE_SAMPLES(PRE)) dut (
    .clock(clock), .reset(reset), .adc_valid(adc_valid), .adc_data(adc_data),
    .arm(arm), .abort(abort), .trig_level(trig_level), .trig_rising(trig_rising),
    .post_count(post_count),
`ifdef CAPTURE_DECIM_EN
    .decim(decim),
`endif
    .write_en(write_en), .write_addr(write_addr), .wr_data(wr_data), .busy(busy),
    .triggered(triggered), .done(done), .trig_addr(trig_addr), .start_addr(start_addr)
  );

  always #5 clock = ~clock;

  typedef struct {
    int addr;
    int data;
  } wr_t;
  wr_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int wr_count = 0;

  // Behavioural reference: capture described as counts of accepted samples.
  bit m_busy, m_trig, m_done, m_hist, m_rise;
  int m_ptr, m_cnt, m_prev, m_lvl, m_post, m_rem, m_tad, m_start, m_vcount, m_decim;

  task automatic model_reset();
    exp_q.delete();
    m_busy = 0; m_trig = 0; m_done = 0; m_hist = 0; m_rise = 0;
    m_ptr = 0; m_cnt = 0; m_prev = 0; m_lvl = 0; m_post = 0; m_rem = 0;
    m_tad = 0; m_start = 0; m_vcount = 0; m_decim = 0;
  endtask

  task automatic model_finish();
    m_busy  = 0;
    m_done  = 1;
    m_start = m_ptr % 4096;
  endtask

  task automatic model_step();
    bit fire;
    int s;
    if (abort) begin
      m_busy = 0; m_trig = 0; m_done = 0;
    end else if (arm && !m_busy) begin
      m_lvl = trig_level; m_rise = trig_rising; m_post = post_count;
      m_ptr = 0; m_cnt = 0; m_hist = 0; m_trig = 0; m_done = 0; m_tad = 0;
      m_busy = 1; m_vcount = 0;
`ifdef CAPTURE_DECIM_EN
      m_decim = decim;
`endif
    end else if (m_busy && adc_valid) begin
      if ((m_vcount % (m_decim + 1)) == 0) begin
        s = adc_data;
        exp_q.push_back('{addr: m_ptr % 4096, data: s});
        if (!m_trig) begin
          fire = m_hist && (m_cnt >= PRE) &&
                 (m_rise ? (m_prev < m_lvl && s >= m_lvl) : (m_prev > m_lvl && s <= m_lvl));
          if (fire) begin
            m_trig = 1;
            m_tad  = m_ptr % 4096;
            m_rem  = m_post;
          end
        end else begin
          m_rem = m_rem - 1;
        end
        m_ptr = m_ptr + 1;
        m_cnt = m_cnt + 1;
        m_prev = s;
        m_hist = 1;
        if (m_trig && m_rem == 0) model_finish();
      end
      m_vcount = m_vcount + 1;
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      checks++;
      if (write_en !== 1'b0) begin
        errors++;
        $display("FAIL write_en_in_reset: got %b want 0", write_en);
      end
    end else if (write_en) begin
      wr_t e;
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0d with nothing expected", write_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if (write_addr !== e.addr[11:0] || wr_data !== e.data[7:0]) begin
          errors++;
          $display("FAIL write: got addr %0d data %0d want addr %0d data %0d",
                   write_addr, wr_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic cycle(input logic v, input int d, input logic a, input logic ab);
    adc_valid = v;
    adc_data  = d[7:0];
    arm       = a;
    abort     = ab;
    @(posedge clock);
    model_step();
    #1;
    arm   = 1'b0;
    abort = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_status(input string name);
    check_val({name, "_busy"}, busy, m_busy);
    check_val({name, "_triggered"}, triggered, m_trig);
    check_val({name, "_done"}, done, m_done);
    check_val({name, "_trig_addr"}, trig_addr, m_tad);
    check_val({name, "_start_addr"}, start_addr, m_start);
    check_val({name, "_pending_writes"}, exp_q.size(), 0);
  endtask

  task automatic setup(input int lvl, input logic rise, input int post);
    trig_level  = lvl[7:0];
    trig_rising = rise;
    post_count  = post[11:0];
  endtask

  int base;
  int d;

  initial begin
    model_reset();
    #12;
    check_val("reset_outputs",
              {write_en, write_addr, wr_data, busy, triggered, done, trig_addr, start_addr}, 0);
    #9 reset = 1'b0;

    // Rising ramp: trigger at sample 100, 10 post samples.
    setup(100, 1'b1, 10);
    base = wr_count;
    cycle(1'b0, 0, 1'b1, 1'b0);
    for (int k = 0; k < 256; k++) cycle(1'b1, k, 1'b0, 1'b0);
    idle(3);
    check_status("ramp");
    check_val("ramp_trig_addr_const", trig_addr, 100);
    check_val("ramp_start_addr_const", start_addr, 111);
    check_val("ramp_write_count", wr_count - base, 111);
    check_val("ramp_done_const", done, 1);

    // Early crossing inside pre-fill window is ignored.
    cycle(1'b0, 0, 1'b1, 1'b0);
    for (int k = 0; k < 80; k++)
      cycle(1'b1, (k < 5) ? 0 : (k < 20) ? 150 : (k < 40) ? 0 : 200, 1'b0, 1'b0);
    idle(3);
    check_status("prefill");
    check_val("prefill_trig_addr_const", trig_addr, 40);

    // Falling trigger after wrap, post_count=4095.
    setup(50, 1'b0, 4095);
    cycle(1'b0, 0, 1'b1, 1'b0);
    for (int k = 0; k < 10000 && m_busy; k++) cycle(1'b1, (k < 5000) ? 200 : 10, 1'b0, 1'b0);
    idle(3);
    check_status("wrap");
    check_val("wrap_trig_addr_const", trig_addr, 904);
    check_val("wrap_start_addr_const", start_addr, 904);

    // Abort after 3 post-trigger samples, then arm+abort together.
    setup(100, 1'b1, 10);
    cycle(1'b0, 0, 1'b1, 1'b0);
    for (int k = 0; k < 104; k++) cycle(1'b1, k, 1'b0, 1'b0);
    cycle(1'b1, 104, 1'b0, 1'b1);
    for (int k = 105; k < 130; k++) cycle(1'b1, k, 1'b0, 1'b0);
    check_status("abort");
    check_val("abort_triggered_const", triggered, 0);
    cycle(1'b1, 7, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) cycle(1'b1, k, 1'b0, 1'b0);
    check_status("arm_abort");
    check_val("arm_abort_busy_const", busy, 0);

    // Reset mid-stream with valid high.
    setup(100, 1'b1, 10);
    cycle(1'b0, 0, 1'b1, 1'b0);
    for (int k = 0; k < 30; k++) cycle(1'b1, k, 1'b0, 1'b0);
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    check_val("midreset_outputs",
              {write_en, write_addr, wr_data, busy, triggered, done, trig_addr, start_addr}, 0);
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    reset = 1'b0;
    adc_valid = 1'b0;

`ifdef CAPTURE_DECIM_EN
    decim = 8'd3;
    setup(100, 1'b1, 10);
    cycle(1'b0, 0, 1'b1, 1'b0);
    for (int k = 0; k < 256; k++) cycle(1'b1, k, 1'b0, 1'b0);
    idle(3);
    check_status("decim");
    check_val("decim_trig_addr_const", trig_addr, 25);
    decim = 8'd0;
`endif

    // Randomized captures: random-walk data, gaps in valid, stray arm pulses.
    for (int r = 0; r < 8; r++) begin
      setup($urandom_range(20, 230), 1'($urandom_range(0, 1)), $urandom_range(0, 40));
      d = $urandom_range(0, 255);
      cycle(1'b0, 0, 1'b1, 1'b0);
      for (int k = 0; k < 600 && m_busy; k++) begin
        d = d + $urandom_range(0, 80) - 40;
        if (d < 0) d = 0;
        if (d > 255) d = 255;
        cycle(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 60) == 0), 1'b0);
      end
      if (m_busy) cycle(1'b0, 0, 1'b0, 1'b1);
      idle(3);
      check_status("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
